// File: rtl/lcd_frame_refresher_pkg.sv
// rtl/lcd_frame_refresher_pkg.sv - shared LCD geometry, character and state definitions
package lcd_frame_refresher_pkg;

  localparam int LINE_LEN   = 16;
  localparam int LINE2_BASE = 16;
  localparam int FRAME_LEN  = 2 * LINE_LEN;

  localparam logic [7:0] SPACE_CHAR = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CURSOR,
    ST_WAIT_C,
    ST_DATA,
    ST_WAIT_D,
    ST_CLEAR,
    ST_WAIT_CLR
  } state_e;

endpackage

// File: rtl/lcd_frame_refresher_if.sv
// rtl/lcd_frame_refresher_if.sv - frame write port plus LCD controller command port
interface lcd_frame_refresher_if;

  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh_req;
  logic       clear_req;
  logic       init_done;
  logic       op_done;
  logic [7:0] Pos;
  logic       Set_Cursor;
  logic [7:0] Data;
  logic       Set_Data;
  logic       Clr_Screen;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  modport slave (
    input  wr_en, wr_addr, wr_data, refresh_req, clear_req, init_done, op_done,
    output Pos, Set_Cursor, Data, Set_Data, Clr_Screen, busy, frame_done, timeout_err
  );

  modport master (
    output wr_en, wr_addr, wr_data, refresh_req, clear_req, init_done, op_done,
    input  Pos, Set_Cursor, Data, Set_Data, Clr_Screen, busy, frame_done, timeout_err
  );

endinterface

// File: rtl/lcd_frame_refresher_dirty_pick.sv
// rtl/lcd_frame_refresher_dirty_pick.sv - lowest-set-bit priority encoder over the dirty mask
module lcd_dirty_pick
  import lcd_frame_refresher_pkg::*;
(
  input  logic [FRAME_LEN-1:0] mask_i,
  output logic [4:0]           idx_o,
  output logic                 any_o
);

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    for (int i = FRAME_LEN - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = 5'(i);
    end
  end

endmodule

// File: rtl/lcd_frame_refresher.sv
// rtl/lcd_frame_refresher.sv - 2x16 frame buffer with dirty-tracked push to an LCD1602 controller
module lcd_frame_refresher #(
  parameter int LINE_LEN = 16,
  parameter int TIMEOUT  = 2_000_000,
  parameter int TO_W     = 21
) (
  input  logic                  Clk,
  input  logic                  Rst,
  lcd_frame_refresher_if.slave  bus
);
  import lcd_frame_refresher_pkg::*;

  state_e          state_q, state_d;
  logic [31:0]     dirty_q, dirty_d;
  logic [7:0]      buf_q [32];
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      cur_pos_q, cur_pos_d;
  logic            cur_valid_q, cur_valid_d;
  logic            clr_pend_q, clr_pend_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      pos_q, pos_d;
  logic [7:0]      data_q, data_d;
  logic            set_cursor_q, set_data_q, clr_screen_q;
  logic            frame_done_q, frame_done_d;
  logic            timeout_err_q, timeout_err_d;

  logic [4:0]      pick_idx;
  logic            pick_any;
  logic            waiting;
  logic            to_hit;
  logic            line_end;
  logic [4:0]      data_addr;
  logic [7:0]      data_src;

  lcd_dirty_pick u_pick (
    .mask_i (dirty_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign waiting  = (state_q == ST_WAIT_C) || (state_q == ST_WAIT_D) || (state_q == ST_WAIT_CLR);
  assign to_hit   = waiting && !bus.op_done && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign line_end = (idx_q == 5'(LINE2_BASE - 1)) || (idx_q == 5'(LINE2_BASE + LINE_LEN - 1));
  assign to_cnt_d = waiting ? to_cnt_q + 1'b1 : '0;

  // A write landing in the cycle the character is latched must be the value sent.
  assign data_addr = (state_q == ST_IDLE) ? pick_idx : idx_q;
  assign data_src  = (bus.wr_en && bus.wr_addr == data_addr) ? bus.wr_data : buf_q[data_addr];

  always_comb begin
    dirty_d    = dirty_q;
    clr_pend_d = clr_pend_q;
    if (state_q == ST_DATA) dirty_d[idx_q] = 1'b0;
    if (bus.refresh_req)    dirty_d = '1;
    if (bus.wr_en)          dirty_d[bus.wr_addr] = 1'b1;
    if (bus.clear_req)      clr_pend_d = 1'b1;
    if (state_q == ST_CLEAR) begin
      dirty_d    = '0;
      clr_pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cur_pos_d     = cur_pos_q;
    cur_valid_d   = cur_valid_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.init_done) begin
          if (clr_pend_q) begin
            state_d = ST_CLEAR;
          end else if (pick_any) begin
            idx_d   = pick_idx;
            state_d = (cur_valid_q && cur_pos_q == pick_idx) ? ST_DATA : ST_CURSOR;
          end
        end
      end
      ST_CURSOR: state_d = ST_WAIT_C;
      ST_DATA:   state_d = ST_WAIT_D;
      ST_CLEAR:  state_d = ST_WAIT_CLR;
      ST_WAIT_C: begin
        if (bus.op_done) begin
          cur_pos_d   = idx_q;
          cur_valid_d = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_WAIT_D: begin
        if (bus.op_done) begin
          cur_pos_d    = idx_q + 5'd1;
          cur_valid_d  = !line_end;
          state_d      = ST_IDLE;
          frame_done_d = (dirty_d == '0) && !clr_pend_d;
        end
      end
      ST_WAIT_CLR: begin
        if (bus.op_done) begin
          cur_pos_d   = '0;
          cur_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_hit) begin
      timeout_err_d = 1'b1;
      cur_valid_d   = 1'b0;
      state_d       = ST_IDLE;
    end
  end

  always_comb begin
    pos_d  = pos_q;
    data_d = data_q;
    if (state_d == ST_CURSOR) pos_d  = {3'b000, idx_d};
    if (state_d == ST_DATA)   data_d = data_src;
  end

  // Strobes are registered on entry to their one-cycle state.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      dirty_q       <= '0;
      idx_q         <= '0;
      cur_pos_q     <= '0;
      cur_valid_q   <= 1'b0;
      clr_pend_q    <= 1'b0;
      to_cnt_q      <= '0;
      pos_q         <= '0;
      data_q        <= '0;
      set_cursor_q  <= 1'b0;
      set_data_q    <= 1'b0;
      clr_screen_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      idx_q         <= idx_d;
      cur_pos_q     <= cur_pos_d;
      cur_valid_q   <= cur_valid_d;
      clr_pend_q    <= clr_pend_d;
      to_cnt_q      <= to_cnt_d;
      pos_q         <= pos_d;
      data_q        <= data_d;
      set_cursor_q  <= (state_d == ST_CURSOR);
      set_data_q    <= (state_d == ST_DATA);
      clr_screen_q  <= (state_d == ST_CLEAR);
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= SPACE_CHAR;
    end else if (state_q == ST_CLEAR) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= SPACE_CHAR;
    end else if (bus.wr_en) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.Pos         = pos_q;
  assign bus.Data        = data_q;
  assign bus.Set_Cursor  = set_cursor_q;
  assign bus.Set_Data    = set_data_q;
  assign bus.Clr_Screen  = clr_screen_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lcd_frame_refresher.sv
// tb/tb_lcd_frame_refresher.sv - bench with an LCD display model acting as the controller
`timescale 1ns/1ps
module tb_lcd_frame_refresher;

  localparam int TO = 40;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  lcd_frame_refresher_if bus ();

  lcd_frame_refresher #(.LINE_LEN(16), .TIMEOUT(TO), .TO_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_frame [32];
  logic [7:0] lcd [32];
  int         lcd_cur = -1;
  bit         pending = 0;
  bit         hold_ack = 0;
  int         ack_dly = 0;
  int         n_cur, n_dat, n_clr, n_fd;
  logic [7:0] pos_log [$];
  logic [7:0] dat_log [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Controller/display model: applies each command to a DDRAM image and acks after a random delay.
  initial begin
    forever begin
      @(negedge Clk);
      bus.op_done = 1'b0;
      if (bus.frame_done) n_fd++;
      if (bus.Set_Cursor || bus.Set_Data || bus.Clr_Screen) begin
        check_eq("one_strobe", 32'($countones({bus.Set_Cursor, bus.Set_Data, bus.Clr_Screen})), 1);
        check_eq("no_reissue", 32'(pending), 0);
        pending = 1;
        ack_dly = $urandom_range(0, 3);
        if (bus.Set_Cursor) begin
          n_cur++;
          pos_log.push_back(bus.Pos);
          lcd_cur = (bus.Pos < 8'd32) ? int'(bus.Pos) : -1;
        end
        if (bus.Set_Data) begin
          n_dat++;
          dat_log.push_back(bus.Data);
          check_eq("cursor_known", 32'(lcd_cur >= 0), 1);
          if (lcd_cur >= 0) begin
            lcd[lcd_cur] = bus.Data;
            lcd_cur = (lcd_cur == 15 || lcd_cur == 31) ? -1 : lcd_cur + 1;
          end
        end
        if (bus.Clr_Screen) begin
          n_clr++;
          for (int i = 0; i < 32; i++) lcd[i] = 8'h20;
          lcd_cur = 0;
        end
      end else if (pending && !hold_ack && !Rst) begin
        if (ack_dly == 0) begin
          bus.op_done = 1'b1;
          pending = 0;
        end else begin
          ack_dly--;
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic clear_counts();
    n_cur = 0; n_dat = 0; n_clr = 0; n_fd = 0;
    pos_log.delete();
    dat_log.delete();
  endtask

  task automatic write_char(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    exp_frame[a] = d;
    @(negedge Clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_refresh();
    bus.refresh_req = 1'b1;
    @(negedge Clk);
    bus.refresh_req = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear_req = 1'b1;
    for (int i = 0; i < 32; i++) exp_frame[i] = 8'h20;
    @(negedge Clk);
    bus.clear_req = 1'b0;
  endtask

  task automatic wait_quiet(input int max_cycles);
    int q = 0;
    int t = 0;
    while (q < 3 && t < max_cycles) begin
      @(negedge Clk);
      t++;
      if (!bus.busy && !pending) q++;
      else q = 0;
    end
    check_eq("settle", 32'(q >= 3), 1);
  endtask

  task automatic wait_strobe(input bit want_data);
    bit ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge Clk);
      if (want_data ? bus.Set_Data : bus.Set_Cursor) ok = 1;
    end
    check_eq(want_data ? "see_set_data" : "see_set_cursor", 32'(ok), 1);
  endtask

  task automatic check_frame(input string tag, input int lo, input int hi);
    int bad = 0;
    for (int i = lo; i <= hi; i++) if (lcd[i] !== exp_frame[i]) bad++;
    check_eq(tag, bad, 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.refresh_req = 0; bus.clear_req = 0; bus.init_done = 0; bus.op_done = 0;
    for (int i = 0; i < 32; i++) begin exp_frame[i] = 8'h20; lcd[i] = 8'h20; end
    clear_counts();
    tick(3);
    check_eq("rst_outputs", 32'({bus.Pos, bus.Data, bus.Set_Cursor, bus.Set_Data, bus.Clr_Screen,
                                 bus.busy, bus.frame_done, bus.timeout_err}), 0);
    Rst = 1'b0;
    bus.init_done = 1'b1;
    tick(2);

    // Basic write
    clear_counts();
    write_char(5, 8'h41);
    wait_quiet(200);
    check_eq("basic_ncur", n_cur, 1);
    check_eq("basic_pos", 32'(pos_log[0]), 5);
    check_eq("basic_ndat", n_dat, 1);
    check_eq("basic_data", 32'(dat_log[0]), 32'h41);
    check_eq("basic_frame_done", n_fd, 1);
    check_eq("basic_busy", 32'(bus.busy), 0);
    check_frame("basic_frame", 0, 31);

    // Cursor reuse across consecutive addresses
    clear_counts();
    write_char(5, 8'h61); write_char(6, 8'h62); write_char(7, 8'h63);
    wait_quiet(200);
    check_eq("reuse_ncur", n_cur, 1);
    check_eq("reuse_pos", 32'(pos_log[0]), 5);
    check_eq("reuse_ndat", n_dat, 3);
    check_eq("reuse_last", 32'(dat_log[2]), 32'h63);
    write_char(8, 8'h64);
    check_eq("lat_early", 32'(bus.Set_Data), 0);
    tick(1);
    check_eq("lat_set_data", 32'(bus.Set_Data), 1);
    check_eq("lat_data", 32'(bus.Data), 32'h64);
    wait_quiet(200);

    // Line boundary forces a second cursor
    clear_counts();
    write_char(15, 8'h4c); write_char(16, 8'h4d);
    wait_quiet(200);
    check_eq("line_ncur", n_cur, 2);
    check_eq("line_pos0", 32'(pos_log[0]), 15);
    check_eq("line_pos1", 32'(pos_log[1]), 16);
    check_eq("line_ndat", n_dat, 2);
    check_frame("line_frame", 0, 31);

    // Clear priority over pending dirty entries
    clear_counts();
    for (int i = 0; i < 10; i++) write_char(5'(20 + i), 8'($urandom_range(33, 126)));
    wait_strobe(1);
    tick(1);
    begin
      int base;
      base = n_dat;
      pulse_clear();
      wait_quiet(400);
      check_eq("clr_no_more_data", n_dat, base);
    end
    check_eq("clr_nclr", n_clr, 1);
    check_eq("clr_no_frame_done", n_fd, 0);
    check_frame("clr_frame", 0, 31);
    clear_counts();
    pulse_refresh();
    wait_quiet(1500);
    check_eq("refresh_ndat", n_dat, 32);
    check_eq("refresh_ncur", n_cur, 1);
    check_eq("refresh_frame_done", n_fd, 1);
    check_frame("refresh_frame", 0, 31);

    // Rewrite during the character's own Set_Data cycle
    clear_counts();
    write_char(3, 8'h78);
    wait_strobe(1);
    write_char(3, 8'h79);
    wait_quiet(300);
    check_eq("coll_ndat", n_dat, 2);
    check_eq("coll_first", 32'(dat_log[0]), 32'h78);
    check_eq("coll_second", 32'(dat_log[1]), 32'h79);
    check_eq("coll_frame_done", n_fd, 1);
    check_frame("coll_frame", 0, 31);

    // Timeout while waiting for the cursor ack
    clear_counts();
    hold_ack = 1;
    write_char(9, 8'h54);
    wait_strobe(0);
    tick(TO);
    check_eq("to_not_yet", 32'({bus.timeout_err, bus.busy}), 32'b01);
    tick(1);
    check_eq("to_fired", 32'({bus.timeout_err, bus.busy}), 32'b10);
    pending = 0;
    hold_ack = 0;
    wait_quiet(300);
    check_eq("to_ncur", n_cur, 2);
    check_eq("to_repos", 32'(pos_log[1]), 9);
    check_eq("to_sticky", 32'(bus.timeout_err), 1);
    check_frame("to_frame", 0, 31);

    // Reset during WAIT_D, then init gating
    clear_counts();
    write_char(12, 8'h52);
    wait_strobe(1);
    tick(1);
    Rst = 1'b1;
    tick(1);
    check_eq("rst_mid_outputs", 32'({bus.Pos, bus.Data, bus.Set_Cursor, bus.Set_Data, bus.Clr_Screen,
                                     bus.busy, bus.frame_done, bus.timeout_err}), 0);
    tick(1);
    Rst = 1'b0;
    pending = 0;
    for (int i = 0; i < 32; i++) exp_frame[i] = 8'h20;
    bus.init_done = 1'b0;
    clear_counts();
    for (int i = 0; i < 4; i++) write_char(5'(i), 8'(8'h30 + i));
    tick(20);
    check_eq("gate_no_strobes", n_cur + n_dat + n_clr, 0);
    check_eq("gate_idle", 32'(bus.busy), 0);
    bus.init_done = 1'b1;
    wait_quiet(300);
    check_eq("gate_ndat", n_dat, 4);
    check_frame("gate_frame", 0, 3);
    pulse_clear();
    wait_quiet(300);
    check_frame("resync_frame", 0, 31);

    // Randomized writes and refreshes against the display model
    for (int r = 0; r < 4; r++) begin
      clear_counts();
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 99) < 45) begin
          bus.wr_en = 1'b1;
          bus.wr_addr = 5'($urandom_range(0, 31));
          bus.wr_data = 8'($urandom_range(33, 126));
          exp_frame[bus.wr_addr] = bus.wr_data;
        end else begin
          bus.wr_en = 1'b0;
        end
        bus.refresh_req = ($urandom_range(0, 99) < 4);
        @(negedge Clk);
      end
      bus.wr_en = 1'b0;
      bus.refresh_req = 1'b0;
      wait_quiet(3000);
      check_frame("rand_frame", 0, 31);
      check_eq("rand_frame_done", 32'(n_fd > 0), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
